// File: rtl/acc_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_bank_pkg
// Description : Shared op encodings, FSM state type and width helper for the
//               accumulator bank.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_bank_pkg;

    // Op encodings carried on in_op
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // Bank controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Channel index width; a single channel still needs one index bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_bank_if
// Description : Op, result, readback and sweep-control signals of the
//               accumulator bank. master = requester, slave = bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_bank_if
    import acc_bank_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int IW  = 8
);
    localparam int CW = ch_width(NCH);

    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ch;
    logic [1:0]    in_op;
    logic [IW-1:0] in_data;
    logic          clear_all;
    logic          res_valid;
    logic [CW-1:0] res_ch;
    logic [W-1:0]  res_data;
    logic          res_ovf;
    logic [CW-1:0] rd_ch;
    logic [W-1:0]  rd_data;
    logic          rd_ovf;
    logic          busy;

    modport master (
        output in_valid, in_ch, in_op, in_data, clear_all, rd_ch,
        input  in_ready, res_valid, res_ch, res_data, res_ovf, rd_data, rd_ovf, busy
    );

    modport slave (
        input  in_valid, in_ch, in_op, in_data, clear_all, rd_ch,
        output in_ready, res_valid, res_ch, res_data, res_ovf, rd_data, rd_ovf, busy
    );

endinterface
`default_nettype wire

// File: rtl/acc_alu.sv
`default_nettype none
// ============================================================================
// Module      : acc_alu
// Description : Combinational next-value unit for one accumulator channel.
//               ADD/SUB evaluated at W+1 bits; carry/borrow reported as ovf
//               and optionally clamped.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_alu
    import acc_bank_pkg::*;
#(
    parameter int W   = 16,
    parameter int SAT = 0
) (
    input  wire logic [W-1:0] i_acc,
    input  wire logic [W-1:0] i_operand,
    input  wire logic [1:0]   i_op,
    output logic      [W-1:0] o_nxt,
    output logic              o_ovf
);

    localparam bit c_SAT = (SAT != 0);

    logic [W:0] w_sum;
    logic [W:0] w_diff;

    // Select next value per op; the extra top bit is carry (ADD) or borrow (SUB)
    always_comb begin
        w_sum  = {1'b0, i_acc} + {1'b0, i_operand};
        w_diff = {1'b0, i_acc} - {1'b0, i_operand};
        o_nxt  = i_acc;
        o_ovf  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_ovf = w_sum[W];
                o_nxt = (c_SAT && w_sum[W]) ? {W{1'b1}} : w_sum[W-1:0];
            end
            OP_SUB: begin
                o_ovf = w_diff[W];
                o_nxt = (c_SAT && w_diff[W]) ? {W{1'b0}} : w_diff[W-1:0];
            end
            OP_LOAD: o_nxt = i_operand;
            default: o_nxt = {W{1'b0}};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_bank.sv
`default_nettype none
// ============================================================================
// Module      : acc_bank
// Description : NCH independent W-bit accumulators behind a valid/ready op
//               port, with sticky overflow flags, registered readback and a
//               one-channel-per-cycle clear-all sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_bank
    import acc_bank_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int IW  = 8,
    parameter int SAT = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    acc_bank_if.slave   bus
);

    localparam int CW = ch_width(NCH);

    logic [W-1:0]  r_acc [NCH];
    logic [NCH-1:0] r_ovf;
    state_t        r_state;
    logic [CW-1:0] r_idx;
    logic          r_busy;
    logic          r_res_valid;
    logic [CW-1:0] r_res_ch;
    logic [W-1:0]  r_res_data;
    logic          r_res_ovf;
    logic [W-1:0]  r_rd_data;
    logic          r_rd_ovf;

    logic          w_ready;
    logic          w_fire;
    logic          w_ch_ok;
    logic [W-1:0]  w_sel_acc;
    logic [W-1:0]  w_rd_acc;
    logic          w_rd_ovf;
    logic [W-1:0]  w_operand;
    logic [W-1:0]  w_alu_nxt;
    logic          w_alu_ovf;

    assign w_ready   = (r_state == ST_IDLE) && !bus.clear_all;
    assign w_fire    = bus.in_valid && w_ready && w_ch_ok;
    assign w_operand = W'(bus.in_data);

    // Channel muxes for the op target and the readback; out-of-range indices select zero
    always_comb begin
        w_ch_ok   = 1'b0;
        w_sel_acc = '0;
        w_rd_acc  = '0;
        w_rd_ovf  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.in_ch == CW'(i)) begin
                w_ch_ok   = 1'b1;
                w_sel_acc = r_acc[i];
            end
            if (bus.rd_ch == CW'(i)) begin
                w_rd_acc = r_acc[i];
                w_rd_ovf = r_ovf[i];
            end
        end
    end

    // Single ALU serves the whole bank since at most one op is accepted per cycle
    acc_alu #(
        .W   (W),
        .SAT (SAT)
    ) u_alu (
        .i_acc     (w_sel_acc),
        .i_operand (w_operand),
        .i_op      (bus.in_op),
        .o_nxt     (w_alu_nxt),
        .o_ovf     (w_alu_ovf)
    );

    // Controller FSM, channel state and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
            r_ovf       <= '0;
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
            r_rd_data   <= '0;
            r_rd_ovf    <= 1'b0;
        end else begin
            // Readback samples the pre-update channel state
            r_rd_data   <= w_rd_acc;
            r_rd_ovf    <= w_rd_ovf;
            r_res_valid <= w_fire;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_all) begin
                        r_state <= ST_SWEEP;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_fire) begin
                        for (int i = 0; i < NCH; i++) begin
                            if (bus.in_ch == CW'(i)) begin
                                r_acc[i] <= w_alu_nxt;
                                if (bus.in_op == OP_CLR) r_ovf[i] <= 1'b0;
                                else if (w_alu_ovf)     r_ovf[i] <= 1'b1;
                            end
                        end
                        r_res_ch   <= bus.in_ch;
                        r_res_data <= w_alu_nxt;
                        r_res_ovf  <= w_alu_ovf;
                    end
                end
                ST_SWEEP: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (r_idx == CW'(i)) begin
                            r_acc[i] <= '0;
                            r_ovf[i] <= 1'b0;
                        end
                    end
                    if (r_idx == CW'(NCH - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_ch    = r_res_ch;
    assign bus.res_data  = r_res_data;
    assign bus.res_ovf   = r_res_ovf;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_ovf    = r_rd_ovf;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_acc_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_bank
// Description : Directed bench for acc_bank. Three instances share stimulus:
//               u_dut0 (NCH=4, wrap), u_dut1 (NCH=4, saturate) and
//               u_dut2 (NCH=3, wrap). Inputs change and outputs are sampled
//               on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_bank;
    import acc_bank_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid;
    logic [1:0] in_ch;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       clear_all;
    logic [1:0] rd_ch;
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    acc_bank_if #(.NCH(4), .W(16), .IW(8)) b0 ();
    acc_bank_if #(.NCH(4), .W(16), .IW(8)) b1 ();
    acc_bank_if #(.NCH(3), .W(16), .IW(8)) b2 ();

    assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;  assign b2.in_valid = in_valid;
    assign b0.in_ch    = in_ch;     assign b1.in_ch    = in_ch;     assign b2.in_ch    = in_ch;
    assign b0.in_op    = in_op;     assign b1.in_op    = in_op;     assign b2.in_op    = in_op;
    assign b0.in_data  = in_data;   assign b1.in_data  = in_data;   assign b2.in_data  = in_data;
    assign b0.clear_all = clear_all; assign b1.clear_all = clear_all; assign b2.clear_all = clear_all;
    assign b0.rd_ch    = rd_ch;     assign b1.rd_ch    = rd_ch;     assign b2.rd_ch    = rd_ch;

    acc_bank #(.NCH(4), .W(16), .IW(8), .SAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    acc_bank #(.NCH(4), .W(16), .IW(8), .SAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    acc_bank #(.NCH(3), .W(16), .IW(8), .SAT(0)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] d);
        in_valid = 1'b1;
        in_op    = op;
        in_ch    = ch;
        in_data  = d;
    endtask

    // ch3 = 0x34 + 18*0xFF + 0x12 = 0x1234
    task automatic build_ch3();
        drive_op(OP_LOAD, 2'd3, 8'h34);
        tick();
        drive_op(OP_ADD, 2'd3, 8'hFF);
        repeat (18) tick();
        drive_op(OP_ADD, 2'd3, 8'h12);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int ovf0;
        int ovf1;
        int busy_cnt;
        int rv_cnt;
        in_valid  = 1'b0;
        in_ch     = 2'd0;
        in_op     = OP_ADD;
        in_data   = 8'h00;
        clear_all = 1'b0;
        rd_ch     = 2'd0;

        // ---------------- reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_res_valid", b0.res_valid, 0);
        check("rst_res_data",  b0.res_data, 0);
        check("rst_rd_data",   b1.rd_data, 0);
        check("rst_busy",      b0.busy, 0);
        check("rst_in_ready",  b0.in_ready, 1);

        // ---------------- back-to-back ADD 5 to ch1
        drive_op(OP_ADD, 2'd1, 8'h05);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("b2b_valid", b0.res_valid, 1);
            check("b2b_data",  b0.res_data, 32'(5 * k));
            check("b2b_ch",    b0.res_ch, 1);
        end
        in_valid = 1'b0;
        rd_ch    = 2'd1;
        tick();
        check("b2b_pulse_end", b0.res_valid, 0);
        check("rd_ch1",        b0.rd_data, 32'h19);
        rd_ch = 2'd0; tick(); check("rd_ch0", b0.rd_data, 0);
        rd_ch = 2'd2; tick(); check("rd_ch2", b0.rd_data, 0);
        rd_ch = 2'd3; tick(); check("rd_ch3", b0.rd_data, 0);

        // ---------------- channel index beyond NCH on the 3-channel bank
        drive_op(OP_ADD, 2'd3, 8'h01);
        tick();
        check("oor_drop_valid", b2.res_valid, 0);
        check("oor_ok_valid4",  b0.res_valid, 1);
        in_valid = 1'b0;
        rd_ch    = 2'd3;
        tick();
        check("oor_rd3",   b2.rd_data, 0);
        check("ch3_rd_n4", b0.rd_data, 1);

        // ---------------- LOAD 0xFF then 257 x ADD 0xFF on ch2
        drive_op(OP_LOAD, 2'd2, 8'hFF);
        tick();
        check("load_data", b0.res_data, 32'hFF);
        check("load_ovf",  b0.res_ovf, 0);
        drive_op(OP_ADD, 2'd2, 8'hFF);
        ovf0 = 0;
        ovf1 = 0;
        for (int k = 0; k < 257; k++) begin
            tick();
            if (b0.res_valid && b0.res_ovf) ovf0++;
            if (b1.res_valid && b1.res_ovf) ovf1++;
        end
        check("wrap_final",     b0.res_data, 32'h00FE);
        check("sat_final",      b1.res_data, 32'hFFFF);
        check("wrap_ovf_count", ovf0, 1);
        check("sat_ovf_count",  ovf1, 1);
        tick();
        check("wrap_more",     b0.res_data, 32'h01FD);
        check("wrap_more_ovf", b0.res_ovf, 0);
        check("sat_hold",      b1.res_data, 32'hFFFF);
        check("sat_hold_ovf",  b1.res_ovf, 1);
        in_valid = 1'b0;
        rd_ch    = 2'd2;
        tick();
        check("sticky_wrap", b0.rd_ovf, 1);
        check("sticky_sat",  b1.rd_ovf, 1);

        // ---------------- SUB 1 from ch0 = 0, then CLR
        drive_op(OP_SUB, 2'd0, 8'h01);
        tick();
        check("sub_wrap",     b0.res_data, 32'hFFFF);
        check("sub_wrap_ovf", b0.res_ovf, 1);
        check("sub_sat",      b1.res_data, 32'h0000);
        check("sub_sat_ovf",  b1.res_ovf, 1);
        in_valid = 1'b0;
        rd_ch    = 2'd0;
        tick();
        check("sub_sticky0", b0.rd_ovf, 1);
        check("sub_sticky1", b1.rd_ovf, 1);
        drive_op(OP_CLR, 2'd0, 8'h00);
        tick();
        check("clr_data", b0.res_data, 0);
        check("clr_ovf",  b0.res_ovf, 0);
        in_valid = 1'b0;
        tick();
        check("clr_sticky0", b0.rd_ovf, 0);
        check("clr_sticky1", b1.rd_ovf, 0);

        // ---------------- clear_all sweep with a pending op held
        clear_all = 1'b1;
        drive_op(OP_ADD, 2'd1, 8'h01);
        busy_cnt = 0;
        rv_cnt   = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            clear_all = 1'b0;
            if (b0.busy && !b0.in_ready) busy_cnt++;
            if (b0.res_valid) rv_cnt++;
        end
        check("sweep_busy_cycles", busy_cnt, 4);
        check("sweep_no_result",   rv_cnt, 0);
        tick();
        check("sweep_end_busy",  b0.busy, 0);
        check("sweep_end_ready", b0.in_ready, 1);
        tick();
        check("pending_valid", b0.res_valid, 1);
        check("pending_data",  b0.res_data, 1);
        in_valid = 1'b0;
        rd_ch    = 2'd2;
        tick();
        check("sweep_rd2",     b0.rd_data, 0);
        check("sweep_rd2_ovf", b0.rd_ovf, 0);
        rd_ch = 2'd3; tick(); check("sweep_rd3", b0.rd_data, 0);

        // ---------------- reset in the middle of a sweep
        build_ch3();
        rd_ch = 2'd3;
        tick();
        check("ch3_built", b0.rd_data, 32'h1234);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("sweep2_busy", b0.busy, 1);
        tick();
        check("ch3_before_rst", b0.rd_data, 32'h1234);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy",     b0.busy, 0);
        check("mrst_ready",    b0.in_ready, 1);
        check("mrst_res_data", b0.res_data, 0);
        check("mrst_rd_data",  b0.rd_data, 0);
        check("mrst_res_ch",   b0.res_ch, 0);
        tick();
        check("mrst_ch3", b0.rd_data, 0);
        check("mrst_busy2", b0.busy, 0);

        // ---------------- same-cycle op and read on ch1
        drive_op(OP_LOAD, 2'd1, 8'h20);
        tick();
        drive_op(OP_ADD, 2'd1, 8'h10);
        rd_ch = 2'd1;
        tick();
        in_valid = 1'b0;
        check("rw_pre",     b0.rd_data, 32'h20);
        check("rw_res",     b0.res_data, 32'h30);
        tick();
        check("rw_post",    b0.rd_data, 32'h30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Parametrised successor to the single 16-bit free-running accumulator.
- Holds NCH independent W-bit accumulators, each updated through a valid/ready op port.
- Ops: add, subtract, load, clear. Selectable wrap or saturate arithmetic, sticky per-channel overflow flags, and a multi-cycle clear-all sweep.
- Sits between the tile input pins and the output mux. One result and one readback per cycle.

Parameters:
- NCH, 4, number of accumulator channels (≥1).
- W, 16, accumulator width in bits.
- IW, 8, operand width in bits (IW ≤ W).
- SAT, 0, 0 = modular wrap; 1 = clamp at 2^W−1 (add) or 0 (sub).
- CW, max(1,$clog2(NCH)), channel index width (derived localparam, not overridable).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  op request.
- in_ready  out  1  op accept; high in IDLE when clear_all is low.
- in_ch  in  CW  target channel.
- in_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLR.
- in_data  in  IW  unsigned operand, zero-extended to W.
- clear_all  in  1  start sweep-clear of all channels and flags.
- res_valid  out  1  one-cycle pulse, result of accepted op.
- res_ch  out  CW  channel of result.
- res_data  out  W  new accumulator value.
- res_ovf  out  1  overflow/underflow occurred on this op (not sticky).
- rd_ch  in  CW  readback channel.
- rd_data  out  W  registered value of acc[rd_ch].
- rd_ovf  out  1  registered sticky flag of rd_ch.
- busy  out  1  high during SWEEP.

Behaviour:
- Reset (rst=1 at edge):
  - All acc = 0 and all sticky flags = 0 in one cycle.
  - State → IDLE.
  - res_valid, res_ch, res_data, res_ovf, rd_data, rd_ovf, busy = 0.
  - Reset mid-sweep aborts the sweep; reset wins over every other input.
- FSM states:
  - IDLE: in_ready = !clear_all. clear_all=1 → SWEEP with idx=0.
  - SWEEP: each cycle acc[idx]=0 and ovf[idx]=0, then idx++. After idx=NCH−1 → IDLE. Lasts exactly NCH cycles.
  - busy=1 and in_ready=0 throughout SWEEP. clear_all is ignored during SWEEP.
- Handshake:
  - An op is accepted when in_valid & in_ready at a clock edge.
  - An accepted op updates acc[in_ch] at that edge.
  - res_* are registered: valid the cycle after acceptance, pulse 1 cycle.
  - Back-to-back ops accepted every cycle. Same-channel back-to-back ops chain correctly, with no hazard.
  - If in_ch ≥ NCH the op is accepted and dropped: no state change, no res_valid.
- Arithmetic (computed at W+1 bits):
  - ADD: carry out → ovf.
  - SUB: borrow → ovf.
  - SAT=0: result = low W bits.
  - SAT=1: clamp to 2^W−1 on ADD overflow, to 0 on SUB borrow.
  - LOAD: acc = zext(in_data), ovf=0.
  - CLR: acc = 0, sticky flag of that channel cleared.
  - ADD/SUB with ovf=1 set the sticky flag; ovf=0 leaves it unchanged.
- Readback:
  - rd_data/rd_ovf are 1-cycle registered copies of the channel state.
  - On a same-cycle op and read of one channel, the read returns the pre-update value.
  - rd_ch ≥ NCH reads 0.

Decomposition:
- Package acc_bank_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_LOAD, OP_CLR;
  - FSM state enum ST_IDLE, ST_SWEEP.
- Sub-module acc_alu (combinational): inputs acc, operand, op, SAT; outputs next value and ovf. One instance, shared by all channels because only one op is accepted per cycle.

Test Plan:
- Reset, then ADD 0x05 to ch1 five times back-to-back → res_data 5, 10, 15, 20, 25 on consecutive cycles. rd_ch=1 then gives 0x0019; ch0/2/3 read 0.
- SAT=0, W=16: LOAD 0xFF ch2, then ADD 0xFF ×257 → final res_data 0x00FE, res_ovf pulse once, rd_ovf(ch2)=1. SAT=1 repeat → value holds 0xFFFF.
- SUB 0x01 from ch0=0 → SAT=0 gives 0xFFFF; SAT=1 gives 0x0000. Both give res_ovf=1 and sticky set. A later CLR ch0 clears the flag.
- NCH=4: clear_all with in_valid held high → in_ready=0 and busy=1 for exactly 4 cycles. All acc and flags read 0 afterwards, and the pending op is accepted on the first IDLE cycle.
- rst asserted at sweep cycle 2 while ch3=0x1234 → next cycle all outputs 0, state IDLE, ch3 reads 0.
- Simultaneous ADD 0x10 to ch1 (value 0x20) and rd_ch=1 → rd_data=0x0020 the next cycle, 0x0030 the cycle after. An op with in_ch ≥ NCH (NCH=3, ch3) produces no res_valid.
